jump_pc: RTL and testbench

- Program counter with Hack-style jump evaluation for the CPU datapath.
- Sits directly downstream of the zero-detect stage: consumes the 16-bit ALU result and reduces it internally, one 8-bit OR reduction per half, to derive zr and ng.
- Evaluates the 3-bit jump field and selects the next pc: reset, hold, jump, or increment.
- Detects the tight-loop halt idiom (jump to its own address), freezes, and reports it.

---
 rtl/jump_pc.sv | 167 ++++++++++++++++
 tb/tb_jump_pc.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/jump_pc.sv
// ---------------------------------------------------------------------------
// jump_pc
//
// Program counter with Hack-style jump evaluation. The ALU result is
// reduced to zero/negative flags. The 3-bit jump field then picks the next
// pc: hold, jump to target, or increment. A taken jump whose target is the
// current pc is the tight-loop halt idiom. When it is seen, the counter
// freezes in HALT until resume is asserted.
//
// Parameters:
//   WIDTH       width of pc, target and alu_out
//   RESET_ADDR  pc value loaded on reset
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active-low (overrides everything)
//   alu_out      ALU result of the current instruction
//   jump         {j1,j2,j3}: jump if negative, zero, positive
//   target       jump destination (A register)
//   instr_valid  current instruction is valid this cycle
//   stall        hold pc and all state this cycle
//   resume       leave HALT state (ignored while stalled or in RUN)
//   pc           current instruction address
//   taken        registered: the last update was a jump
//   halted       high while in HALT state
//   zr           combinational: alu_out == 0
//   ng           combinational: alu_out MSB
//   jump_count   (only with JUMP_PC_COUNT_EN) saturating count of taken
//                jumps, halt entries included
//
// Optional feature: define JUMP_PC_COUNT_EN to add the jump_count output.
// ---------------------------------------------------------------------------
module jump_pc #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [2:0]       jump,
    input  logic [WIDTH-1:0] target,
    input  logic             instr_valid,
    input  logic             stall,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic             taken,
    output logic             halted,
    output logic             zr,
    output logic             ng
`ifdef JUMP_PC_COUNT_EN
    ,
    output logic [15:0]      jump_count
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Zero detect is built from 8-bit OR reductions. alu_out is zero-padded
    // up to a whole number of bytes so that any WIDTH works.
    localparam int NUM_CHUNKS = (WIDTH + 7) / 8;
    localparam int PAD_W      = NUM_CHUNKS * 8;

    logic [PAD_W-1:0]      alu_pad;
    logic [NUM_CHUNKS-1:0] chunk_or;

    assign alu_pad = PAD_W'(alu_out);

    generate
        for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
            assign chunk_or[gi] = |alu_pad[gi*8 +: 8];
        end
    endgenerate

    assign zr = ~|chunk_or;
    assign ng = alu_out[WIDTH-1];

    logic cond;
    assign cond = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic             taken_reg, taken_next;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        taken_next = taken_reg;
        if (!stall) begin
            case (state_reg)
                ST_RUN: begin
                    if (instr_valid) begin
                        if (cond) begin
                            taken_next = 1'b1;
                            // Jumping to ourselves is the halt idiom. pc
                            // already equals target, so pc is left as is.
                            if (target == pc_reg) begin
                                state_next = ST_HALT;
                            end else begin
                                pc_next = target;
                            end
                        end else begin
                            pc_next    = pc_reg + WIDTH'(1);
                            taken_next = 1'b0;
                        end
                    end else begin
                        taken_next = 1'b0;
                    end
                end
                ST_HALT: begin
                    // instr_valid, jump and target are ignored here.
                    if (resume) begin
                        pc_next    = pc_reg + WIDTH'(1);
                        taken_next = 1'b0;
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            pc_reg    <= RESET_ADDR;
            taken_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            taken_reg <= taken_next;
        end
    end

    assign pc     = pc_reg;
    assign taken  = taken_reg;
    assign halted = (state_reg == ST_HALT);

`ifdef JUMP_PC_COUNT_EN
    // A jump "fires" whenever the RUN-state taken path is chosen. This
    // covers both the plain jump and the halt entry.
    logic        jump_fire;
    logic [15:0] count_reg, count_next;

    assign jump_fire = !stall && (state_reg == ST_RUN) && instr_valid && cond;

    always_comb begin
        count_next = count_reg;
        if (jump_fire && (count_reg != 16'hFFFF)) begin
            count_next = count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= 16'd0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign jump_count = count_reg;
`endif

endmodule

// File: tb/tb_jump_pc.sv
module tb_jump_pc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] alu_out;
    logic [2:0]  jump;
    logic [15:0] target;
    logic        instr_valid;
    logic        stall;
    logic        resume;
    logic [15:0] pc;
    logic        taken;
    logic        halted;
    logic        zr;
    logic        ng;
`ifdef JUMP_PC_COUNT_EN
    logic [15:0] jump_count;
`endif

    jump_pc #(.WIDTH(16), .RESET_ADDR(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_out     (alu_out),
        .jump        (jump),
        .target      (target),
        .instr_valid (instr_valid),
        .stall       (stall),
        .resume      (resume),
        .pc          (pc),
        .taken       (taken),
        .halted      (halted),
        .zr          (zr),
        .ng          (ng)
`ifdef JUMP_PC_COUNT_EN
        ,
        .jump_count  (jump_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        iv;
        logic        resume;
        logic [2:0]  jump;
        logic [15:0] alu;
        logic [15:0] tgt;
        logic [15:0] exp_pc;
        logic        exp_taken;
        logic        chk_taken;
        logic        exp_halted;
        logic [15:0] exp_cnt;
        logic        chk_cnt;
    } vec_t;

    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_txn    = 0;

    function automatic vec_t mk(input logic r, input logic s, input logic v,
                                input logic res, input logic [2:0] j,
                                input logic [15:0] a, input logic [15:0] t,
                                input logic [15:0] epc, input logic etk,
                                input logic ehl);
        vec_t x;
        x.rst_n = r; x.stall = s; x.iv = v; x.resume = res; x.jump = j;
        x.alu = a; x.tgt = t; x.exp_pc = epc; x.exp_taken = etk;
        x.chk_taken = 1'b1; x.exp_halted = ehl; x.exp_cnt = '0;
        x.chk_cnt = 1'b0;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one transaction, push its expectation, then pop and compare
    // after the edge.
    task automatic run(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst_n = v.rst_n; stall = v.stall; instr_valid = v.iv;
        resume = v.resume; jump = v.jump; alu_out = v.alu; target = v.tgt;
        #1;
        chk("zr", {31'b0, zr}, {31'b0, (v.alu == 16'h0000)});
        chk("ng", {31'b0, ng}, {31'b0, v.alu[15]});
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_txn++;
        chk("pc", {16'b0, pc}, {16'b0, e.exp_pc});
        if (e.chk_taken) chk("taken", {31'b0, taken}, {31'b0, e.exp_taken});
        chk("halted", {31'b0, halted}, {31'b0, e.exp_halted});
`ifdef JUMP_PC_COUNT_EN
        if (e.chk_cnt) chk("jump_count", {16'b0, jump_count}, {16'b0, e.exp_cnt});
`endif
        $display("txn %0d: rst_n=%b stall=%b iv=%b res=%b j=%b alu=%h tgt=%h -> pc=%h taken=%b halted=%b zr=%b ng=%b",
                 n_txn, v.rst_n, v.stall, v.iv, v.resume, v.jump, v.alu, v.tgt,
                 pc, taken, halted, zr, ng);
    endtask

    vec_t tbl[16];
    vec_t v;

    initial begin
        rst_n = 1'b0; stall = 1'b0; instr_valid = 1'b0; resume = 1'b0;
        jump = 3'b000; alu_out = 16'h0000; target = 16'h0000;

        // Reset overrides stall and a valid jump request.
        for (int i = 0; i < 2; i++) begin
            v = mk(0, 1, 1, 0, 3'b111, 16'h0000, 16'h0055, 16'h0000, 0, 0);
            v.chk_cnt = 1'b1; v.exp_cnt = 16'd0;
            run(v);
        end
        // Release: plain increments 1, 2, 3.
        for (int i = 1; i <= 3; i++)
            run(mk(1, 0, 1, 0, 3'b000, 16'h1234, 16'h0000, 16'(i), 0, 0));

        // Single-cycle vectors, starting from pc=3.
        tbl[0]  = mk(1, 0, 1, 0, 3'b010, 16'h0000, 16'h0040, 16'h0040, 1, 0);
        tbl[1]  = mk(1, 0, 1, 0, 3'b010, 16'h8000, 16'h0099, 16'h0041, 0, 0);
        tbl[2]  = mk(1, 0, 1, 0, 3'b001, 16'h0100, 16'h0200, 16'h0200, 1, 0);
        tbl[3]  = mk(1, 0, 1, 0, 3'b010, 16'h0001, 16'h0300, 16'h0201, 0, 0);
        tbl[4]  = mk(1, 0, 1, 0, 3'b010, 16'h0100, 16'h0300, 16'h0202, 0, 0);
        tbl[5]  = mk(1, 0, 1, 0, 3'b100, 16'hFFFF, 16'h0500, 16'h0500, 1, 0);
        tbl[6]  = mk(1, 0, 0, 0, 3'b111, 16'h0000, 16'h0700, 16'h0500, 0, 0);
        tbl[7]  = mk(1, 0, 1, 0, 3'b000, 16'h1234, 16'h0700, 16'h0501, 0, 0);
        tbl[8]  = mk(1, 0, 1, 0, 3'b111, 16'h1234, 16'h0600, 16'h0600, 1, 0);
        tbl[9]  = mk(1, 0, 1, 0, 3'b101, 16'h0000, 16'h0000, 16'h0601, 0, 0);
        tbl[10] = mk(1, 0, 1, 0, 3'b110, 16'h7FFF, 16'h0000, 16'h0602, 0, 0);
        tbl[11] = mk(1, 0, 1, 0, 3'b111, 16'h0000, 16'hFFFF, 16'hFFFF, 1, 0);
        tbl[12] = mk(1, 0, 1, 0, 3'b000, 16'h0001, 16'h0000, 16'h0000, 0, 0);
        tbl[13] = mk(1, 0, 1, 1, 3'b000, 16'h0001, 16'h0000, 16'h0001, 0, 0);
        tbl[14] = mk(1, 0, 1, 0, 3'b011, 16'h0002, 16'h0010, 16'h0010, 1, 0);
        tbl[15] = mk(1, 0, 1, 0, 3'b000, 16'h0000, 16'h0010, 16'h0011, 0, 0);
        for (int i = 0; i < 16; i++) run(tbl[i]);

        // Get taken=1 first, then stall a jump request for 4 cycles.
        run(mk(1, 0, 1, 0, 3'b111, 16'h0000, 16'h0010, 16'h0010, 1, 0));
        for (int i = 0; i < 4; i++)
            run(mk(1, 1, 1, 0, 3'b111, 16'h0000, 16'h0020, 16'h0010, 1, 0));
        run(mk(1, 0, 1, 0, 3'b111, 16'h0000, 16'h0020, 16'h0020, 1, 0));

        // Halt: jump to 0x0010, then jump-to-self.
        run(mk(1, 0, 1, 0, 3'b111, 16'h0000, 16'h0010, 16'h0010, 1, 0));
        run(mk(1, 0, 1, 0, 3'b111, 16'h0000, 16'h0010, 16'h0010, 1, 1));
        for (int i = 0; i < 5; i++) begin
            v = mk(1, 0, 1, 0, 3'b111, 16'h0000, 16'h0077, 16'h0010, 0, 1);
            v.chk_taken = 1'b0;
            run(v);
        end
        // Resume while stalled is ignored.
        v = mk(1, 1, 0, 1, 3'b000, 16'h0001, 16'h0000, 16'h0010, 0, 1);
        v.chk_taken = 1'b0;
        run(v);
        run(mk(1, 0, 0, 1, 3'b000, 16'h0001, 16'h0000, 16'h0011, 0, 0));
        // Re-halt at 0x0011, then reset while halted.
        run(mk(1, 0, 1, 0, 3'b001, 16'h0005, 16'h0011, 16'h0011, 1, 1));
        run(mk(0, 0, 0, 0, 3'b000, 16'h0001, 16'h0000, 16'h0000, 0, 0));

        // Count: 3 taken, 2 untaken, 1 halt entry -> 4.
        v = mk(1, 0, 1, 0, 3'b111, 16'h0000, 16'h0100, 16'h0100, 1, 0);
        v.chk_cnt = 1'b1; v.exp_cnt = 16'd1; run(v);
        v = mk(1, 0, 1, 0, 3'b000, 16'h0000, 16'h0300, 16'h0101, 0, 0);
        v.chk_cnt = 1'b1; v.exp_cnt = 16'd1; run(v);
        v = mk(1, 0, 1, 0, 3'b111, 16'h0001, 16'h0200, 16'h0200, 1, 0);
        v.chk_cnt = 1'b1; v.exp_cnt = 16'd2; run(v);
        v = mk(1, 0, 1, 0, 3'b010, 16'h8000, 16'h0300, 16'h0201, 0, 0);
        v.chk_cnt = 1'b1; v.exp_cnt = 16'd2; run(v);
        v = mk(1, 0, 1, 0, 3'b111, 16'h0000, 16'h0300, 16'h0300, 1, 0);
        v.chk_cnt = 1'b1; v.exp_cnt = 16'd3; run(v);
        v = mk(1, 0, 1, 0, 3'b111, 16'h0000, 16'h0300, 16'h0300, 1, 1);
        v.chk_cnt = 1'b1; v.exp_cnt = 16'd4; run(v);

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
